// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key gesture classifier.
//   - FSM state encoding (3-bit constants)
//   - event-code enum, also used by the calculator control decoder
//   - max3 helper used to size the shared counter
package key_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        EvNone  = 3'd0,
        EvClick = 3'd1,
        EvDbl   = 3'd2,
        EvLong  = 3'd3,
        EvRpt   = 3'd4
    } key_evt_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_if.sv
// key_event_if: key level in, gesture pulses and busy flag out.
//   key_level : debounced key level, 1 = released, 0 = pressed
//   click_o   : single-click pulse
//   dbl_o     : double-click pulse
//   long_o    : long-press pulse
//   rpt_o     : auto-repeat pulse
//   busy_o    : classifier not idle
// master = key source / event consumer, slave = classifier.
interface key_event_if;
    logic key_level;
    logic click_o;
    logic dbl_o;
    logic long_o;
    logic rpt_o;
    logic busy_o;

    modport master (
        output key_level,
        input  click_o, dbl_o, long_o, rpt_o, busy_o
    );

    modport slave (
        input  key_level,
        output click_o, dbl_o, long_o, rpt_o, busy_o
    );
endinterface

// File: rtl/key_edge.sv
// key_edge: press/release edge detector for an active-low key level.
//   clk, rst    : clock, async active-high reset
//   i_key_level : key level, 1 = released, 0 = pressed
//   o_press     : falling edge of the level (new press)
//   o_release   : rising edge of the level (release)
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_key_level,
    output logic o_press,
    output logic o_release
);

    logic r_key_d;
    // Set once the key has been seen released after reset. A key already held
    // when reset deasserts would otherwise look like a press against r_key_d=1.
    logic r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_d <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_key_d <= i_key_level;
            r_armed <= r_armed | i_key_level;
        end
    end

    assign o_press   = r_armed & r_key_d & ~i_key_level;
    assign o_release = ~r_key_d & i_key_level;

endmodule

// File: rtl/key_event.sv
// key_event: classifies debounced key interactions into click, double click,
// long press and auto-repeat; every result is a registered one-cycle pulse.
//   clk, rst : clock, async active-high reset
//   bus      : key_event_if slave (key_level in; click/dbl/long/rpt/busy out)
// Parameters (all >= 2): LONG_CNT hold time to long press, DBL_CNT double-click
// window after first release, RPT_CNT auto-repeat period while held.
module key_event
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT = 25_000_000,
    parameter int unsigned DBL_CNT  = 12_500_000,
    parameter int unsigned RPT_CNT  = 5_000_000
) (
    input logic        clk,
    input logic        rst,
    key_event_if.slave bus
);

    localparam int unsigned CntW = $clog2(max3(LONG_CNT, DBL_CNT, RPT_CNT));
    localparam logic [CntW-1:0] LongTc = CntW'(LONG_CNT - 1);
    localparam logic [CntW-1:0] DblTc  = CntW'(DBL_CNT - 1);
    localparam logic [CntW-1:0] RptTc  = CntW'(RPT_CNT - 1);

    logic            w_press;
    logic            w_release;
    logic [2:0]      r_state;
    logic [2:0]      w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            w_rpt_reload;
    key_evt_e        w_evt;
    logic            r_click;
    logic            r_dbl;
    logic            r_long;
    logic            r_rpt;
    logic            r_busy;

    key_edge u_edge (
        .clk         (clk),
        .rst         (rst),
        .i_key_level (bus.key_level),
        .o_press     (w_press),
        .o_release   (w_release)
    );

    // Release/press checks come first so they win over a coincident terminal count.
    always_comb begin
        w_state_d    = r_state;
        w_evt        = EvNone;
        w_rpt_reload = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) w_state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (w_release) begin
                    w_state_d = ST_WAIT2;
                end else if (r_cnt == LongTc) begin
                    w_state_d = ST_LONG;
                    w_evt     = EvLong;
                end
            end
            ST_WAIT2: begin
                if (w_press) begin
                    w_state_d = ST_PRESS2;
                    w_evt     = EvDbl;
                end else if (r_cnt == DblTc) begin
                    w_state_d = ST_IDLE;
                    w_evt     = EvClick;
                end
            end
            ST_PRESS2: begin
                if (w_release) w_state_d = ST_IDLE;
            end
            ST_LONG: begin
                if (w_release) begin
                    w_state_d = ST_IDLE;
                end else if (r_cnt == RptTc) begin
                    w_evt        = EvRpt;
                    w_rpt_reload = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Held at zero in IDLE so the counter cannot wrap while the key is untouched.
    always_comb begin
        if ((w_state_d != r_state) || w_rpt_reload || (r_state == ST_IDLE)) begin
            w_cnt_d = '0;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_click <= 1'b0;
            r_dbl   <= 1'b0;
            r_long  <= 1'b0;
            r_rpt   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_click <= (w_evt == EvClick);
            r_dbl   <= (w_evt == EvDbl);
            r_long  <= (w_evt == EvLong);
            r_rpt   <= (w_evt == EvRpt);
            r_busy  <= (w_state_d != ST_IDLE);
        end
    end

    assign bus.click_o = r_click;
    assign bus.dbl_o   = r_dbl;
    assign bus.long_o  = r_long;
    assign bus.rpt_o   = r_rpt;
    assign bus.busy_o  = r_busy;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed self-checking bench for key_event (LONG=20, DBL=10, RPT=5).
module tb_key_event;

    logic clk;
    logic rst;

    key_event_if u_if ();

    key_event #(
        .LONG_CNT (20),
        .DBL_CNT  (10),
        .RPT_CNT  (5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse log, sampled just after each rising edge; cyc = edge number.
    int n_click, n_dbl, n_long, n_rpt, n_multi;
    int t_click, t_dbl, t_long, t_rpt, t_rpt_first, t_busy_rise, t_busy_fall;
    logic prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (u_if.click_o) begin n_click++; t_click = cyc; end
        if (u_if.dbl_o)   begin n_dbl++;   t_dbl   = cyc; end
        if (u_if.long_o)  begin n_long++;  t_long  = cyc; end
        if (u_if.rpt_o) begin
            if (n_rpt == 0) t_rpt_first = cyc;
            n_rpt++;
            t_rpt = cyc;
        end
        if ((32'(u_if.click_o) + 32'(u_if.dbl_o) + 32'(u_if.long_o) + 32'(u_if.rpt_o)) > 1)
            n_multi++;
        if (!prev_busy && u_if.busy_o) t_busy_rise = cyc;
        if (prev_busy && !u_if.busy_o) t_busy_fall = cyc;
        prev_busy = u_if.busy_o;
    end

    task automatic clear_log();
        n_click = 0; n_dbl = 0; n_long = 0; n_rpt = 0;
        t_click = -1; t_dbl = -1; t_long = -1; t_rpt = -1; t_rpt_first = -1;
        t_busy_rise = -1; t_busy_fall = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the key at a falling edge; returns the edge at which it is sampled.
    task automatic set_key(input logic v, output int t_edge);
        u_if.key_level = v;
        t_edge = cyc + 1;
    endtask

    int tp, tr, tp2, tmp;

    initial begin
        rst = 1'b1;
        u_if.key_level = 1'b1;
        clear_log();
        n_multi = 0;
        idle(3);
        rst = 1'b0;
        idle(3);
        check("reset_busy", 32'(u_if.busy_o), 0);
        check("reset_pulses", n_click + n_dbl + n_long + n_rpt, 0);

        // 1: single click
        clear_log();
        set_key(1'b0, tp); idle(5);
        set_key(1'b1, tr); idle(30);
        check("click_count", n_click, 1);
        check("click_time", t_click, tr + 10);
        check("click_other", n_dbl + n_long + n_rpt, 0);
        check("busy_rise", t_busy_rise, tp);
        check("busy_fall", t_busy_fall, tr + 10);

        // 2: double click
        clear_log();
        set_key(1'b0, tp);  idle(3);
        set_key(1'b1, tr);  idle(4);
        set_key(1'b0, tp2); idle(3);
        set_key(1'b1, tmp); idle(30);
        check("dbl_count", n_dbl, 1);
        check("dbl_time", t_dbl, tp2);
        check("dbl_no_click", n_click, 0);

        // 3: long press with auto-repeat
        clear_log();
        set_key(1'b0, tp); idle(42);
        set_key(1'b1, tr); idle(30);
        check("long_count", n_long, 1);
        check("long_time", t_long, tp + 20);
        check("rpt_count", n_rpt, 4);
        check("rpt_first", t_rpt_first, tp + 25);
        check("rpt_last", t_rpt, tp + 40);
        check("long_no_click", n_click + n_dbl, 0);

        // 4a: release on the long terminal cycle
        clear_log();
        set_key(1'b0, tp); idle(20);
        set_key(1'b1, tr); idle(20);
        check("b_rel_edge", tr, tp + 20);
        check("b_no_long", n_long, 0);
        check("b_click_time", t_click, tr + 10);

        // 4b: second press on the click terminal cycle
        clear_log();
        set_key(1'b0, tp);  idle(3);
        set_key(1'b1, tr);  idle(10);
        set_key(1'b0, tp2); idle(2);
        set_key(1'b1, tmp); idle(20);
        check("b_dbl_time", t_dbl, tr + 10);
        check("b_no_click", n_click, 0);

        // 5: reset in LONG with key held
        set_key(1'b0, tp); idle(25);
        rst = 1'b1;
        clear_log();
        idle(3);
        rst = 1'b0;
        idle(30);
        check("rst_pulses", n_click + n_dbl + n_long + n_rpt, 0);
        check("rst_busy", 32'(u_if.busy_o), 0);
        set_key(1'b1, tmp); idle(3);
        set_key(1'b0, tp);  idle(5);
        set_key(1'b1, tr);  idle(15);
        check("rst_click_count", n_click, 1);
        check("rst_click_time", t_click, tr + 10);

        // 6: fast key activity
        clear_log();
        set_key(1'b0, tp);  idle(1);
        set_key(1'b1, tr);  idle(1);
        set_key(1'b0, tp2); idle(1);
        set_key(1'b1, tmp); idle(20);
        check("fast_dbl_time", t_dbl, tp2);
        check("fast_no_click", n_click, 0);
        for (int i = 0; i < 20; i++) begin
            set_key(i[0] ? 1'b1 : 1'b0, tmp);
            idle(1 + (i % 3));
        end
        set_key(1'b1, tmp); idle(40);
        check("fast_idle", 32'(u_if.busy_o), 0);
        check("exclusive", n_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
